// File: rtl/calc_seq_ctrl_pkg.sv
// calc_seq_ctrl_pkg
// Shared definitions for the calculator sequencer slice:
//   - PS/2 set-2 scan codes used by the keypad
//   - ALU operation encodings
//   - FSM state encoding and decoded-key types
//   - decode_key(): maps a non-prefix scan code to a key class/value
package calc_seq_ctrl_pkg;

  // Keypad digit scan codes
  localparam logic [7:0] SC_D0    = 8'h70;
  localparam logic [7:0] SC_D1    = 8'h69;
  localparam logic [7:0] SC_D2    = 8'h72;
  localparam logic [7:0] SC_D3    = 8'h7A;
  localparam logic [7:0] SC_D4    = 8'h6B;
  localparam logic [7:0] SC_D5    = 8'h73;
  localparam logic [7:0] SC_D6    = 8'h74;
  localparam logic [7:0] SC_D7    = 8'h6C;
  localparam logic [7:0] SC_D8    = 8'h75;
  localparam logic [7:0] SC_D9    = 8'h7D;
  // Operator / control scan codes
  localparam logic [7:0] SC_ADD   = 8'h79;
  localparam logic [7:0] SC_SUB   = 8'h7B;
  localparam logic [7:0] SC_MUL   = 8'h7C;
  localparam logic [7:0] SC_DIV   = 8'h4A;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_ESC   = 8'h76;
  // Prefix bytes
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  // ALU operation encodings
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [2:0] {
    ST_ENTER_A = 3'd0,
    ST_ENTER_B = 3'd1,
    ST_EXEC    = 3'd2,
    ST_WAIT    = 3'd3,
    ST_SHOW    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    KC_DIGIT = 2'd0,
    KC_OP    = 2'd1,
    KC_ENTER = 2'd2,
    KC_ESC   = 2'd3
  } key_class_t;

  typedef struct packed {
    logic       hit;
    key_class_t cls;
    logic [3:0] val;
  } key_t;

  // Decode a non-prefix scan code. With the E0 prefix only the keypad
  // '/' and keypad Enter are accepted; other E0 codes are different keys.
  function automatic key_t decode_key(input logic [7:0] code, input logic ext);
    key_t k;
    k.hit = 1'b1;
    k.cls = KC_DIGIT;
    k.val = 4'd0;
    case (code)
      SC_D0:    k.val = 4'd0;
      SC_D1:    k.val = 4'd1;
      SC_D2:    k.val = 4'd2;
      SC_D3:    k.val = 4'd3;
      SC_D4:    k.val = 4'd4;
      SC_D5:    k.val = 4'd5;
      SC_D6:    k.val = 4'd6;
      SC_D7:    k.val = 4'd7;
      SC_D8:    k.val = 4'd8;
      SC_D9:    k.val = 4'd9;
      SC_ADD:   begin k.cls = KC_OP;    k.val = {2'b00, OP_ADD}; end
      SC_SUB:   begin k.cls = KC_OP;    k.val = {2'b00, OP_SUB}; end
      SC_MUL:   begin k.cls = KC_OP;    k.val = {2'b00, OP_MUL}; end
      SC_DIV:   begin k.cls = KC_OP;    k.val = {2'b00, OP_DIV}; end
      SC_ENTER: begin k.cls = KC_ENTER; k.val = 4'd0; end
      SC_ESC:   begin k.cls = KC_ESC;   k.val = 4'd0; end
      default:  k.hit = 1'b0;
    endcase
    if (ext && (code != SC_DIV) && (code != SC_ENTER)) begin
      k.hit = 1'b0;
    end else begin
      k.hit = k.hit;
    end
    return k;
  endfunction

endpackage

// File: rtl/calc_seq_ctrl_if.sv
// calc_seq_ctrl_if
// Start/done handshake between the sequencer (master) and the arithmetic
// unit (slave).
//   alu_start  : one-cycle request; operands/op stable until alu_done
//   alu_op     : 00 add, 01 sub, 10 mul, 11 div
//   alu_a/b    : zero-extended operands, OPW bits
//   alu_done   : one-cycle pulse, alu_result/alu_err valid
//   alu_result : signed 32-bit result
//   alu_err    : operation error (e.g. divide by zero)
interface calc_seq_ctrl_if #(
  parameter int OPW = 16
);
  logic            alu_start;
  logic [1:0]      alu_op;
  logic [OPW-1:0]  alu_a;
  logic [OPW-1:0]  alu_b;
  logic            alu_done;
  logic [31:0]     alu_result;
  logic            alu_err;

  modport master (
    output alu_start, alu_op, alu_a, alu_b,
    input  alu_done, alu_result, alu_err
  );

  modport slave (
    input  alu_start, alu_op, alu_a, alu_b,
    output alu_done, alu_result, alu_err
  );
endinterface

// File: rtl/calc_seq_ctrl_ps2_key_decode.sv
// calc_seq_ctrl_ps2_key_decode
// Filters F0 (break) / E0 (extended) prefixes from the PS/2 byte stream and
// turns key presses into registered one-cycle key events.
//   clk, rst   : clock, synchronous active-high reset
//   rx_valid   : new byte in rx_byte
//   rx_byte    : received scan-code byte
//   key_valid  : one-cycle pulse, key_class/key_val valid
//   key_class  : digit / operator / enter / esc
//   key_val    : digit value, or ALU op code in [1:0] for operators
module calc_seq_ctrl_ps2_key_decode
  import calc_seq_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       key_valid,
  output key_class_t key_class,
  output logic [3:0] key_val
);

  logic brk_r;
  logic ext_r;
  key_t dec_s;

  // Decode the incoming byte in the context of the current E0 flag
  always_comb begin
    dec_s = decode_key(rx_byte, ext_r);
  end

  // Prefix flags and registered key event
  always_ff @(posedge clk) begin
    if (rst) begin
      brk_r     <= 1'b0;
      ext_r     <= 1'b0;
      key_valid <= 1'b0;
      key_class <= KC_DIGIT;
      key_val   <= 4'd0;
    end else begin
      key_valid <= 1'b0;
      if (rx_valid) begin
        if (rx_byte == SC_BRK) begin
          brk_r <= 1'b1;
        end else if (rx_byte == SC_EXT) begin
          ext_r <= 1'b1;
        end else begin
          // Any non-prefix byte closes the prefix sequence; a release is dropped.
          brk_r <= 1'b0;
          ext_r <= 1'b0;
          if (!brk_r && dec_s.hit) begin
            key_valid <= 1'b1;
            key_class <= dec_s.cls;
            key_val   <= dec_s.val;
          end
        end
      end
    end
  end

endmodule

// File: rtl/calc_seq_ctrl.sv
// calc_seq_ctrl
// Calculator sequencer: collects operand A, operator and operand B from
// keypad keys, runs one start/done transaction on the ALU, and latches the
// result for display.
//   clk, rst     : clock, synchronous active-high reset
//   rx_valid     : new PS/2 byte in rx_byte
//   rx_byte      : received scan-code byte
//   alu          : ALU handshake (master side)
//   result       : last completed result
//   result_valid : one-cycle pulse when result updates
//   err          : sticky error of the last operation
//   entry_bcd    : in-progress entry, packed BCD, LSD in [3:0]
//   state_o      : current FSM state (debug)
module calc_seq_ctrl
  import calc_seq_ctrl_pkg::*;
#(
  parameter int MAX_DIGITS = 4,
  parameter int OPW        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_byte,
  calc_seq_ctrl_if.master       alu,
  output logic [31:0]           result,
  output logic                  result_valid,
  output logic                  err,
  output logic [15:0]           entry_bcd,
  output logic [2:0]            state_o
);

  localparam int CNTW = $clog2(MAX_DIGITS + 1);

  logic       key_valid;
  key_class_t key_class;
  logic [3:0] key_val;

  state_t          state_r, state_n;
  logic [OPW-1:0]  acc_r, acc_n;
  logic [CNTW-1:0] cnt_r, cnt_n;
  logic [15:0]     bcd_r, bcd_n;
  logic [1:0]      op_r, op_n;
  logic [OPW-1:0]  a_r, a_n;
  logic [OPW-1:0]  b_r, b_n;
  logic [31:0]     result_r, result_n;
  logic            err_r, err_n;
  logic            start_r, start_n;
  logic            rv_r, rv_n;
  logic            room_s;

  calc_seq_ctrl_ps2_key_decode u_key_decode (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte),
    .key_valid (key_valid),
    .key_class (key_class),
    .key_val   (key_val)
  );

  // Room for another digit in the current operand
  always_comb begin
    room_s = (cnt_r < CNTW'(MAX_DIGITS));
  end

  // Next-state and datapath updates
  always_comb begin
    state_n  = state_r;
    acc_n    = acc_r;
    cnt_n    = cnt_r;
    bcd_n    = bcd_r;
    op_n     = op_r;
    a_n      = a_r;
    b_n      = b_r;
    result_n = result_r;
    err_n    = err_r;
    start_n  = 1'b0;
    rv_n     = 1'b0;

    case (state_r)
      ST_ENTER_A, ST_ENTER_B: begin
        if (key_valid) begin
          case (key_class)
            KC_DIGIT: begin
              if (room_s) begin
                acc_n = acc_r * OPW'(10) + OPW'(key_val);
                bcd_n = {bcd_r[11:0], key_val};
                cnt_n = cnt_r + CNTW'(1);
              end else begin
                acc_n = acc_r;
              end
            end
            KC_OP: begin
              if (state_r == ST_ENTER_A) begin
                if (cnt_r != CNTW'(0)) begin
                  a_n     = acc_r;
                  op_n    = key_val[1:0];
                  acc_n   = {OPW{1'b0}};
                  cnt_n   = {CNTW{1'b0}};
                  bcd_n   = 16'h0000;
                  state_n = ST_ENTER_B;
                end else begin
                  state_n = state_r;
                end
              end else begin
                // Before any B digit, a new operator overrides the old one.
                if (cnt_r == CNTW'(0)) begin
                  op_n = key_val[1:0];
                end else begin
                  op_n = op_r;
                end
              end
            end
            KC_ENTER: begin
              if ((state_r == ST_ENTER_B) && (cnt_r != CNTW'(0))) begin
                b_n     = acc_r;
                acc_n   = {OPW{1'b0}};
                cnt_n   = {CNTW{1'b0}};
                bcd_n   = 16'h0000;
                start_n = 1'b1;
                state_n = ST_EXEC;
              end else begin
                state_n = state_r;
              end
            end
            KC_ESC: begin
              acc_n   = {OPW{1'b0}};
              cnt_n   = {CNTW{1'b0}};
              bcd_n   = 16'h0000;
              err_n   = 1'b0;
              op_n    = OP_ADD;
              state_n = ST_ENTER_A;
            end
            default: state_n = state_r;
          endcase
        end else begin
          state_n = state_r;
        end
      end

      // alu_start was raised on entry to EXEC; it drops as we move on.
      ST_EXEC: state_n = ST_WAIT;

      ST_WAIT: begin
        if (alu.alu_done) begin
          result_n = alu.alu_result;
          err_n    = alu.alu_err;
          rv_n     = 1'b1;
          state_n  = ST_SHOW;
        end else begin
          state_n = state_r;
        end
      end

      ST_SHOW: begin
        // A key decoded while result_valid is high arrived together with
        // alu_done and is dropped.
        if (key_valid && !rv_r) begin
          case (key_class)
            KC_DIGIT: begin
              acc_n   = OPW'(key_val);
              cnt_n   = CNTW'(1);
              bcd_n   = {12'h000, key_val};
              err_n   = 1'b0;
              state_n = ST_ENTER_A;
            end
            KC_ESC: begin
              acc_n   = {OPW{1'b0}};
              cnt_n   = {CNTW{1'b0}};
              bcd_n   = 16'h0000;
              err_n   = 1'b0;
              op_n    = OP_ADD;
              state_n = ST_ENTER_A;
            end
            default: state_n = state_r;
          endcase
        end else begin
          state_n = state_r;
        end
      end

      default: state_n = ST_ENTER_A;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_ENTER_A;
      acc_r    <= {OPW{1'b0}};
      cnt_r    <= {CNTW{1'b0}};
      bcd_r    <= 16'h0000;
      op_r     <= OP_ADD;
      a_r      <= {OPW{1'b0}};
      b_r      <= {OPW{1'b0}};
      result_r <= 32'h0000_0000;
      err_r    <= 1'b0;
      start_r  <= 1'b0;
      rv_r     <= 1'b0;
    end else begin
      state_r  <= state_n;
      acc_r    <= acc_n;
      cnt_r    <= cnt_n;
      bcd_r    <= bcd_n;
      op_r     <= op_n;
      a_r      <= a_n;
      b_r      <= b_n;
      result_r <= result_n;
      err_r    <= err_n;
      start_r  <= start_n;
      rv_r     <= rv_n;
    end
  end

  assign alu.alu_start = start_r;
  assign alu.alu_op    = op_r;
  assign alu.alu_a     = a_r;
  assign alu.alu_b     = b_r;
  assign result        = result_r;
  assign result_valid  = rv_r;
  assign err           = err_r;
  assign entry_bcd     = bcd_r;
  assign state_o       = state_r;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// tb_calc_seq_ctrl
// Directed self-checking bench for calc_seq_ctrl: PS/2 byte sequences are
// driven on rx_valid/rx_byte and the ALU side is played by hand.
module tb_calc_seq_ctrl;

  localparam logic [2:0] S_A    = 3'd0;
  localparam logic [2:0] S_B    = 3'd1;
  localparam logic [2:0] S_EXEC = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_SHOW = 3'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic [31:0] result;
  logic        result_valid;
  logic        err;
  logic [15:0] entry_bcd;
  logic [2:0]  state_o;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int rv_cnt = 0;
  int snap;

  calc_seq_ctrl_if #(.OPW(16)) alu_bus ();

  calc_seq_ctrl #(.MAX_DIGITS(4), .OPW(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_valid     (rx_valid),
    .rx_byte      (rx_byte),
    .alu          (alu_bus),
    .result       (result),
    .result_valid (result_valid),
    .err          (err),
    .entry_bcd    (entry_bcd),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  // Count start and result pulses seen at the clock edge
  always @(posedge clk) begin
    if (alu_bus.alu_start === 1'b1) start_cnt <= start_cnt + 1;
    if (result_valid === 1'b1) rv_cnt <= rv_cnt + 1;
  end

  initial begin
    #300000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
  endtask

  // Make + break of a normal key
  task automatic press(input logic [7:0] b);
    send(b);
    send(8'hF0);
    send(b);
    @(negedge clk);
  endtask

  // Make + break of an E0-prefixed key
  task automatic press_ext(input logic [7:0] b);
    send(8'hE0);
    send(b);
    send(8'hE0);
    send(8'hF0);
    send(b);
    @(negedge clk);
  endtask

  task automatic wait_state(input logic [2:0] s, input string tag);
    int n;
    n = 0;
    while ((state_o !== s) && (n < 50)) begin
      @(negedge clk);
      n++;
    end
    check(tag, {29'd0, state_o}, {29'd0, s});
  endtask

  task automatic alu_return(input logic [31:0] r, input logic e);
    @(negedge clk);
    alu_bus.alu_done   = 1'b1;
    alu_bus.alu_result = r;
    alu_bus.alu_err    = e;
    @(negedge clk);
    alu_bus.alu_done   = 1'b0;
    alu_bus.alu_result = 32'd0;
    alu_bus.alu_err    = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_byte = 8'h00;
    alu_bus.alu_done = 1'b0;
    alu_bus.alu_result = 32'd0;
    alu_bus.alu_err = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", {29'd0, state_o}, {29'd0, S_A});
    check("rst_result", result, 32'd0);
    check("rst_rv", {31'd0, result_valid}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_bcd", {16'd0, entry_bcd}, 32'd0);
    check("rst_start", {31'd0, alu_bus.alu_start}, 32'd0);
    check("rst_a", {16'd0, alu_bus.alu_a}, 32'd0);
    rst = 1'b0;

    // 12 + 3 with break codes interleaved
    send(8'h69); send(8'hF0); send(8'h69);
    send(8'h72); send(8'hF0); send(8'h72);
    send(8'h79); send(8'hF0); send(8'h79);
    send(8'h7A); send(8'hF0); send(8'h7A);
    @(negedge clk);
    check("t1_state_b", {29'd0, state_o}, {29'd0, S_B});
    check("t1_bcd_b", {16'd0, entry_bcd}, 32'h0003);
    snap = start_cnt;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_byte  = 8'h5A;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    check("t1_start_early", {31'd0, alu_bus.alu_start}, 32'd0);
    @(negedge clk);
    check("t1_start_t2", {31'd0, alu_bus.alu_start}, 32'd1);
    check("t1_state_exec", {29'd0, state_o}, {29'd0, S_EXEC});
    @(negedge clk);
    check("t1_start_drop", {31'd0, alu_bus.alu_start}, 32'd0);
    check("t1_state_wait", {29'd0, state_o}, {29'd0, S_WAIT});
    check("t1_a", {16'd0, alu_bus.alu_a}, 32'd12);
    check("t1_b", {16'd0, alu_bus.alu_b}, 32'd3);
    check("t1_op", {30'd0, alu_bus.alu_op}, 32'd0);
    check("t1_start_count", start_cnt - snap, 32'd1);
    snap = rv_cnt;
    alu_return(32'd15, 1'b0);
    check("t1_rv", {31'd0, result_valid}, 32'd1);
    check("t1_result", result, 32'd15);
    check("t1_state_show", {29'd0, state_o}, {29'd0, S_SHOW});
    @(negedge clk);
    check("t1_rv_drop", {31'd0, result_valid}, 32'd0);
    check("t1_rv_count", rv_cnt - snap, 32'd1);
    check("t1_bcd_show", {16'd0, entry_bcd}, 32'd0);

    // Five digits, fifth dropped; 1234 + 1
    press(8'h76);
    check("t2_esc_state", {29'd0, state_o}, {29'd0, S_A});
    press(8'h69); press(8'h72); press(8'h7A); press(8'h6B); press(8'h73);
    check("t2_bcd", {16'd0, entry_bcd}, 32'h1234);
    check("t2_state", {29'd0, state_o}, {29'd0, S_A});
    press(8'h79);
    check("t2_bcd_clr", {16'd0, entry_bcd}, 32'd0);
    press(8'h69);
    press(8'h5A);
    wait_state(S_WAIT, "t2_wait");
    check("t2_a", {16'd0, alu_bus.alu_a}, 32'd1234);
    check("t2_b", {16'd0, alu_bus.alu_b}, 32'd1);
    alu_return(32'd1235, 1'b0);
    check("t2_result", result, 32'd1235);

    // 7 / 0 with extended keys; error then cleared by a digit
    press(8'h6C);
    check("t3_state_a", {29'd0, state_o}, {29'd0, S_A});
    check("t3_bcd7", {16'd0, entry_bcd}, 32'h0007);
    press_ext(8'h4A);
    check("t3_state_b", {29'd0, state_o}, {29'd0, S_B});
    press(8'h70);
    press_ext(8'h5A);
    wait_state(S_WAIT, "t3_wait");
    check("t3_op", {30'd0, alu_bus.alu_op}, 32'd3);
    check("t3_a", {16'd0, alu_bus.alu_a}, 32'd7);
    check("t3_b", {16'd0, alu_bus.alu_b}, 32'd0);
    alu_return(32'd0, 1'b1);
    check("t3_err", {31'd0, err}, 32'd1);
    check("t3_state_show", {29'd0, state_o}, {29'd0, S_SHOW});
    press(8'h6B);
    check("t3_err_clr", {31'd0, err}, 32'd0);
    check("t3_bcd4", {16'd0, entry_bcd}, 32'h0004);
    check("t3_state_a2", {29'd0, state_o}, {29'd0, S_A});

    // 5, +, -, 6, Enter: operator replaced
    press(8'h76);
    press(8'h73); press(8'h79); press(8'h7B); press(8'h74); press(8'h5A);
    wait_state(S_WAIT, "t4_wait");
    check("t4_op", {30'd0, alu_bus.alu_op}, 32'd1);
    check("t4_a", {16'd0, alu_bus.alu_a}, 32'd5);
    check("t4_b", {16'd0, alu_bus.alu_b}, 32'd6);
    alu_return(32'hFFFF_FFFF, 1'b0);
    check("t4_result", result, 32'hFFFF_FFFF);

    // Key arriving together with alu_done is dropped
    press(8'h76);
    press(8'h72); press(8'h79); press(8'h7A); press(8'h5A);
    wait_state(S_WAIT, "t5_wait");
    @(negedge clk);
    alu_bus.alu_done   = 1'b1;
    alu_bus.alu_result = 32'd5;
    rx_valid = 1'b1;
    rx_byte  = 8'h7D;
    @(negedge clk);
    alu_bus.alu_done = 1'b0;
    alu_bus.alu_result = 32'd0;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    check("t5_rv", {31'd0, result_valid}, 32'd1);
    check("t5_result", result, 32'd5);
    repeat (3) @(negedge clk);
    check("t5_state_show", {29'd0, state_o}, {29'd0, S_SHOW});
    check("t5_bcd", {16'd0, entry_bcd}, 32'd0);

    // 8, *, Esc: back to ENTER_A, no start
    press(8'h76);
    press(8'h75); press(8'h7C);
    check("t6_state_b", {29'd0, state_o}, {29'd0, S_B});
    check("t6_op_mul", {30'd0, alu_bus.alu_op}, 32'd2);
    snap = start_cnt;
    press(8'h76);
    check("t6_state_a", {29'd0, state_o}, {29'd0, S_A});
    check("t6_bcd", {16'd0, entry_bcd}, 32'd0);
    check("t6_op_clr", {30'd0, alu_bus.alu_op}, 32'd0);
    check("t6_no_start", start_cnt - snap, 32'd0);

    // Reset during WAIT; a late alu_done is ignored
    press(8'h69); press(8'h79); press(8'h69); press(8'h5A);
    wait_state(S_WAIT, "t7_wait");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t7_state", {29'd0, state_o}, {29'd0, S_A});
    check("t7_result", result, 32'd0);
    check("t7_err", {31'd0, err}, 32'd0);
    check("t7_a", {16'd0, alu_bus.alu_a}, 32'd0);
    check("t7_b", {16'd0, alu_bus.alu_b}, 32'd0);
    snap = rv_cnt;
    alu_return(32'd2, 1'b0);
    repeat (3) @(negedge clk);
    check("t7_no_rv", rv_cnt - snap, 32'd0);
    check("t7_result_kept", result, 32'd0);
    check("t7_state_after", {29'd0, state_o}, {29'd0, S_A});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
